// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encoding and nibble width.
package sub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/sub_4bit.sv
// One nibble of subtraction with borrow in and borrow out; reused for every nibble position.
module sub_4bit
  import sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic                bout
);
  logic [NIBBLE_W:0] full;

  // The extra top bit goes to 1 exactly when a - b - bin underflows.
  assign full = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, bin};
  assign d    = full[NIBBLE_W-1:0];
  assign bout = full[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_subtractor.sv
// Subtracts B from A one nibble per cycle, LSB nibble first, with a valid/ready handshake on each side.
// Optional macro SUB_SIGNED_OVF_EN enables the signed-overflow flag Ovf; otherwise Ovf is tied to 0.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Zero,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state;
  logic [WIDTH-1:0]    a_q, b_q, diff_q, diff_next;
  logic [IDX_W-1:0]    idx;
  logic                borrow;
  logic                bout_q, zero_q, ready_q, valid_q;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_d;
  logic                nib_bout;
  logic                accept, last_nib;

  assign accept   = in_valid && ready_q;
  assign last_nib = (idx == LAST_IDX);

  always_comb begin
    nib_a     = a_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
    nib_b     = b_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
    diff_next = diff_q;
    diff_next[int'(idx)*NIBBLE_W +: NIBBLE_W] = nib_d;
  end

  sub_4bit u_sub_4bit (
    .a    (nib_a),
    .b    (nib_b),
    .bin  (borrow),
    .d    (nib_d),
    .bout (nib_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      idx     <= '0;
      borrow  <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= B;
            idx     <= '0;
            borrow  <= 1'b0;
            ready_q <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            diff_q <= diff_next;
            borrow <= nib_bout;
            idx    <= idx + 1'b1;
            if (last_nib) begin
              // Flags are taken from the complete word, registered together with Diff.
              bout_q  <= nib_bout;
              zero_q  <= (diff_next == '0);
              valid_q <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == CALC && !abort && last_nib) begin
      ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_next[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  assign Ovf = ovf_q;
`else
  assign Ovf = 1'b0;
`endif

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign Diff      = diff_q;
  assign Bout      = bout_q;
  assign Zero      = zero_q;
endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port A  input  WIDTH  minuend; sampled on accept.
REQ-005 SHALL have port B  input  WIDTH  subtrahend; sampled on accept.
REQ-006 SHALL have port in_valid  input  1  operands valid.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-009 SHALL have port Diff  output  WIDTH  A minus B, modulo 2^WIDTH.
REQ-010 SHALL have port Bout  output  1  final borrow; 1 when unsigned A is less than B.
REQ-011 SHALL have port Zero  output  1  Diff equals 0.
REQ-012 SHALL have port Ovf  output  1  signed two's-complement overflow.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-015 SHALL run the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; accept = in_valid AND in_ready; on accept, register A and B, clear nibble index and borrow, and enter CALC.
REQ-017 SHALL, in each CALC cycle, subtract one 4-bit nibble (index k, LSB nibble first) with the borrow carried from nibble k-1 (0 for k=0), and register the result nibble and borrow.
REQ-018 SHALL enter DONE after nibble WIDTH/4-1; out_valid rises exactly WIDTH/4 cycles after the accept edge (2 cycles for WIDTH=8).
REQ-019 SHALL hold Diff, Bout, Zero, Ovf and out_valid stable in DONE until out_valid AND out_ready; that edge returns the FSM to IDLE. There is no accept in the same cycle.
REQ-020 SHALL keep out_valid = 0 outside DONE; Diff/Bout/Zero/Ovf are don't-care when out_valid = 0.
REQ-021 SHALL compute Zero from the full registered Diff, not per nibble.
REQ-022 SHALL, on abort in CALC or DONE, return to IDLE on the next edge with out_valid = 0 and discard the result; abort in IDLE is ignored; abort has priority over out_ready.
REQ-023 SHALL ignore in_valid and A/B changes while not in IDLE.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, in_ready = 1, out_valid = 0, Diff = 0, Bout = 0, Zero = 0, Ovf = 0, nibble index = 0, borrow = 0.
REQ-025 SHALL, on reset during CALC or DONE, drop the operation; the first accept after reset release behaves as from power-up.

Configuration
REQ-026 SHALL, when macro SUB_SIGNED_OVF_EN is defined, set Ovf = (A[MSB] != B[MSB]) AND (Diff[MSB] != A[MSB]), registered with Diff.
REQ-027 SHALL, when SUB_SIGNED_OVF_EN is undefined, tie Ovf to constant 0 with no overflow logic present.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, CALC, DONE) and the constant NIBBLE_W = 4 in a shared package, sub_pkg.
REQ-029 SHALL implement the nibble arithmetic as one reused combinational sub-module, sub_4bit (ports: a, b, bin; outputs: d, bout), instantiated once.

Verification
REQ-030 SHALL pass: A=0x92, B=0xAC -> Diff=0xE6, Bout=1, Zero=0, Ovf=0; out_valid 2 cycles after accept.
REQ-031 SHALL pass: A=0xEA, B=0x92 -> Diff=0x58, Bout=0, Zero=0, Ovf=0.
REQ-032 SHALL pass: A=0x7F, B=0xFF -> Diff=0x80, Bout=1, Ovf=1 with the macro and Ovf=0 without it.
REQ-033 SHALL pass: A=0x55, B=0x55 -> Diff=0x00, Zero=1, Bout=0; nibble borrow from 0x10-0x01 case: A=0x10, B=0x01 -> Diff=0x0F, Bout=0.
REQ-034 SHALL pass: out_ready held 0 for 5 cycles -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE the next cycle; new A/B applied while busy are not sampled.
REQ-035 SHALL pass: abort or rst_n low during CALC -> out_valid never rises, in_ready=1 next cycle; a following A=0x03, B=0x01 -> Diff=0x02.
